fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 17 +
 rtl/next_pc_calc.sv | 39 +++
 rtl/fetch_unit.sv | 107 ++++++++++
 tb/tb_fetch_unit.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Optional BR Xn support is enabled by defining FETCH_BR_REG_EN.
package fetch_pkg;

  typedef enum logic [2:0] {
    S_RST,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_ERR
  } state_t;

  localparam logic [63:0] PC_INC = 64'd4;
  localparam int IMM26_W = 26;
  localparam int IMM19_W = 19;

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC generation: sequential, B (imm26) and CBZ/B.cond (imm19).
// FETCH_BR_REG_EN adds a register-target path (BR Xn).
module next_pc_calc
  import fetch_pkg::*;
(
  input  logic [63:0] pc,
  input  logic [31:0] instr,
  input  logic        br_taken,
  input  logic        uncond_br,
`ifdef FETCH_BR_REG_EN
  input  logic        br_reg,
  input  logic [63:0] br_target,
`endif
  output logic [63:0] next_pc
);

  logic [63:0] off26;
  logic [63:0] off19;
  logic [63:0] seq_pc;
  logic [63:0] br_pc;

  assign off26 = {{(64-IMM26_W-2){instr[25]}},
                  instr[25:0], 2'b00};
  assign off19 = {{(64-IMM19_W-2){instr[23]}},
                  instr[23:5], 2'b00};

  assign seq_pc = pc + PC_INC;
  assign br_pc  = pc + (uncond_br ? off26 : off19);

  always_comb begin
    next_pc = br_taken ? br_pc : seq_pc;
`ifdef FETCH_BR_REG_EN
    // Register branch wins over any PC-relative decision.
    if (br_reg)
      next_pc = {br_target[63:2], 2'b00};
`endif
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, imem handshake with timeout, held instr.
// FETCH_BR_REG_EN adds BrReg/BrTarget inputs for BR Xn.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        UncondBr,
  input  logic        BrTaken,
`ifdef FETCH_BR_REG_EN
  input  logic        BrReg,
  input  logic [63:0] BrTarget,
`endif
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] Instruction,
  output logic        instr_valid,
  output logic [63:0] pc,
  output logic        fetch_err
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [63:0]   next_pc;

  next_pc_calc u_npc (
    .pc        (pc),
    .instr     (Instruction),
    .br_taken  (BrTaken),
    .uncond_br (UncondBr),
`ifdef FETCH_BR_REG_EN
    .br_reg    (BrReg),
    .br_target (BrTarget),
`endif
    .next_pc   (next_pc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= S_RST;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_RST:  state_nx = S_REQ;
      S_REQ:  state_nx = S_WAIT;
      S_WAIT: begin
        if (imem_valid)
          state_nx = S_HOLD;
        else if (cnt == CNT_LAST)
          state_nx = S_ERR;
      end
      S_HOLD: if (!stall) state_nx = S_REQ;
      S_ERR:  state_nx = S_ERR;
      default: state_nx = S_RST;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    fetch_err   = 1'b0;
    unique case (1'b1)
      (state == S_REQ):  imem_req    = 1'b1;
      (state == S_HOLD): instr_valid = 1'b1;
      (state == S_ERR):  fetch_err   = 1'b1;
      default: ;
    endcase
  end

  // Data registers only move in the state that owns them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      Instruction <= 32'h0;
      cnt         <= '0;
    end else begin
      unique case (state)
        S_REQ:  cnt <= '0;
        S_WAIT: begin
          if (imem_valid)
            Instruction <= imem_rdata;
          else
            cnt <= cnt + 1'b1;
        end
        S_HOLD: if (!stall) pc <= next_pc;
        default: ;
      endcase
    end
  end

  assign imem_addr = pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit with a reference model.
// Covers FETCH_BR_REG_EN when that macro is defined.
module tb_fetch_unit;

  localparam logic [63:0] RESET_PC = 64'h0;
  localparam int          TIMEOUT  = 16;
  localparam logic [31:0] NOP      = 32'hD503201F;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        UncondBr;
  logic        BrTaken;
`ifdef FETCH_BR_REG_EN
  logic        BrReg;
  logic [63:0] BrTarget;
`endif
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] Instruction;
  logic        instr_valid;
  logic [63:0] pc;
  logic        fetch_err;

  fetch_unit #(
    .RESET_PC (RESET_PC),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .UncondBr    (UncondBr),
    .BrTaken     (BrTaken),
`ifdef FETCH_BR_REG_EN
    .BrReg       (BrReg),
    .BrTarget    (BrTarget),
`endif
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_valid  (imem_valid),
    .Instruction (Instruction),
    .instr_valid (instr_valid),
    .pc          (pc),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [63:0] exp_a[$];
  logic [63:0] exp_ipc[$];
  logic [31:0] exp_iw[$];

  logic [63:0] cur_pc;
  logic [31:0] cur_word;
  logic [63:0] mem_pc;
  logic [31:0] mem_word;
  int          mem_lat  = 1;
  bit          mem_en   = 1'b1;
  int          mem_pend = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [63:0] model_next(
    logic [63:0] p, logic [31:0] w, bit bt, bit ub,
    bit br, logic [63:0] tgt);
    logic signed [25:0] i26;
    logic signed [18:0] i19;
    longint off;
    i26 = w[25:0];
    i19 = w[23:5];
    if (br) return tgt & ~64'd3;
    if (!bt) return p + 64'd4;
    off = ub ? longint'(i26) : longint'(i19);
    return p + 64'(off * 4);
  endfunction

  // Memory model: answers each request after mem_lat cycles.
  always @(posedge clk) begin
    #1;
    imem_valid = 1'b0;
    if (reset) begin
      mem_pend = 0;
    end else begin
      if (mem_pend > 0) begin
        mem_pend--;
        if (mem_pend == 0) begin
          imem_valid = 1'b1;
          imem_rdata = mem_word;
          exp_ipc.push_back(mem_pc);
          exp_iw.push_back(mem_word);
        end
      end
      if (imem_req && mem_en)
        mem_pend = mem_lat;
    end
  end

  // Monitor: pops expectations whenever the DUT presents something.
  always @(negedge clk) begin
    if (!reset) begin
      if (imem_req) begin
        if (exp_a.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_req: got addr %h expected none",
                   imem_addr);
        end else begin
          chk("req_addr", imem_addr, exp_a.pop_front());
        end
      end
      if (instr_valid) begin
        if (exp_iw.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_iv: got pc %h expected none", pc);
        end else begin
          chk("instr", {32'h0, Instruction}, {32'h0, exp_iw[0]});
          chk("pc", pc, exp_ipc[0]);
          if (!stall) begin
            void'(exp_iw.pop_front());
            void'(exp_ipc.pop_front());
          end
        end
      end
    end
  end

  task automatic wait_iv();
    for (int i = 0; i < 60 && !instr_valid; i++) step();
    if (!instr_valid) begin
      n_chk++;
      n_fail++;
      $display("FAIL iv_timeout: got no instr_valid expected one");
    end
  endtask

  task automatic run_instr(int stalls, bit bt, bit ub, bit br,
                           logic [63:0] tgt, logic [31:0] nw,
                           int lat, bit ans);
    logic [63:0] nxt;
    wait_iv();
    for (int k = 0; k < stalls; k++) begin
      stall    = 1'b1;
      BrTaken  = 1'($urandom);
      UncondBr = 1'($urandom);
      step();
      chk("stall_noreq", {63'h0, imem_req}, 64'h0);
      chk("stall_iv", {63'h0, instr_valid}, 64'h1);
    end
    stall    = 1'b0;
    BrTaken  = bt;
    UncondBr = ub;
`ifdef FETCH_BR_REG_EN
    BrReg    = br;
    BrTarget = tgt;
`endif
    nxt = model_next(cur_pc, cur_word, bt, ub, br, tgt);
    exp_a.push_back(nxt);
    mem_pc   = nxt;
    mem_word = nw;
    mem_lat  = lat;
    mem_en   = ans;
    cur_pc   = nxt;
    cur_word = nw;
    step();
    BrTaken  = 1'b0;
    UncondBr = 1'b0;
`ifdef FETCH_BR_REG_EN
    BrReg    = 1'b0;
    BrTarget = 64'h0;
`endif
  endtask

  task automatic restart(logic [31:0] w0);
    exp_a.delete();
    exp_ipc.delete();
    exp_iw.delete();
    cur_pc   = RESET_PC;
    cur_word = w0;
    mem_pc   = RESET_PC;
    mem_word = w0;
    mem_lat  = 1;
    mem_en   = 1'b1;
    exp_a.push_back(RESET_PC);
  endtask

  initial begin
    int t_prev;
    int k;
    reset      = 1'b1;
    stall      = 1'b0;
    UncondBr   = 1'b0;
    BrTaken    = 1'b0;
`ifdef FETCH_BR_REG_EN
    BrReg      = 1'b0;
    BrTarget   = 64'h0;
`endif
    imem_rdata = 32'h0;
    imem_valid = 1'b0;
    repeat (3) step();
    chk("rst_pc", pc, RESET_PC);
    chk("rst_instr", {32'h0, Instruction}, 64'h0);
    chk("rst_iv", {63'h0, instr_valid}, 64'h0);
    chk("rst_req", {63'h0, imem_req}, 64'h0);
    chk("rst_err", {63'h0, fetch_err}, 64'h0);

    restart(NOP);
    reset = 1'b0;

    // Best case sequential: one instruction every 3 cycles.
    t_prev = 0;
    for (int i = 0; i < 3; i++) begin
      wait_iv();
      if (i > 0) chk("cadence", 64'(cyc - t_prev), 64'd3);
      t_prev = cyc;
      run_instr(0, 1'b0, 1'b0, 1'b0, 64'h0,
                (i == 2) ? 32'h1400000D : NOP, 1, 1'b1);
    end
    wait_iv();
    chk("cadence", 64'(cyc - t_prev), 64'd3);
    run_instr(0, 1'b1, 1'b1, 1'b0, 64'h0, 32'h17FFFFFE, 1, 1'b1);
    run_instr(0, 1'b1, 1'b1, 1'b0, 64'h0, 32'h14000032, 1, 1'b1);
    run_instr(0, 1'b1, 1'b1, 1'b0, 64'h0, 32'hB40000A0, 2, 1'b1);
    run_instr(4, 1'b1, 1'b0, 1'b0, 64'h0, NOP, 1, 1'b1);

    for (int i = 0; i < 40; i++) begin
      bit br;
      br = 1'b0;
`ifdef FETCH_BR_REG_EN
      br = ($urandom_range(0, 3) == 0);
`endif
      run_instr($urandom_range(0, 3), 1'($urandom), 1'($urandom),
                br, {$urandom, $urandom}, $urandom,
                $urandom_range(1, 6), 1'b1);
    end

`ifdef FETCH_BR_REG_EN
    run_instr(0, 1'b1, 1'b1, 1'b1, 64'h2003, NOP, 1, 1'b1);
`endif

    // Memory stops answering: expect a sticky timeout.
    run_instr(0, 1'b0, 1'b0, 1'b0, 64'h0, NOP, 1, 1'b0);
    k = 0;
    while (k < 40 && !fetch_err) begin
      step();
      k++;
    end
    chk("timeout_cycles", 64'(k), 64'(TIMEOUT + 1));
    repeat (8) begin
      step();
      chk("err_sticky", {63'h0, fetch_err}, 64'h1);
      chk("err_noiv", {63'h0, instr_valid}, 64'h0);
    end
    chk("err_queue", 64'(exp_a.size()), 64'h0);

    reset = 1'b1;
    #1;
    chk("async_err", {63'h0, fetch_err}, 64'h0);
    chk("async_pc", pc, RESET_PC);
    step();
    restart(32'h12345678);
    reset = 1'b0;
    run_instr(0, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0BADF00D, 1, 1'b1);

    // Reset during WAIT, then a stale response lands in S_RST.
    run_instr(0, 1'b0, 1'b0, 1'b0, 64'h0, NOP, 8, 1'b1);
    repeat (2) step();
    reset = 1'b1;
    #1;
    chk("midwait_pc", pc, RESET_PC);
    chk("midwait_instr", {32'h0, Instruction}, 64'h0);
    step();
    restart(32'hCAFE0001);
    reset = 1'b0;
    #1;
    imem_valid = 1'b1;
    imem_rdata = 32'hDEADBEEF;
    step();
    chk("stale_ignored", {32'h0, Instruction}, 64'h0);
    run_instr(0, 1'b0, 1'b0, 1'b0, 64'h0, NOP, 1, 1'b1);
    wait_iv();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1);
  end

endmodule
